ka193_mul_sched: RTL and testbench

- Sequencer and arbiter that shares one combinational 193-bit carry-less Karatsuba multiplier (KA_193bit, GF(2)[x], 385-bit product) between two requesters.
- Registers the operands and holds them stable for a programmable multicycle settle window, then captures the product and returns it with a valid/ready handshake and a requester tag.
- Sits between the field-arithmetic clients (point-add / inversion units) and the multiplier instance.

---
 rtl/ka193_pkg.sv | 15 +
 rtl/KA_193bit.sv | 38 +++
 rtl/rr_arb2.sv | 24 ++
 rtl/ka193_mul_sched.sv | 145 ++++++++++++++
 tb/tb_ka193_mul_sched.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ka193_pkg.sv
// Shared types and widths for the 193-bit carry-less multiplier scheduler.
package ka193_pkg;

  localparam int FIELD_W = 193;
  localparam int PROD_W  = 2 * FIELD_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/KA_193bit.sv
// Combinational 193x193 carry-less multiplier over GF(2), one Karatsuba level:
// operands split at bit 97 into low (97 bits) and high (96 bits) halves.
module KA_193bit (
  input  logic [192:0] a,
  input  logic [192:0] b,
  output logic [384:0] y
);

  localparam int HW = 97;

  function automatic logic [2*HW-2:0] clmul_half(input logic [HW-1:0] x,
                                                 input logic [HW-1:0] z);
    logic [2*HW-2:0] acc;
    acc = '0;
    for (int i = 0; i < HW; i++) begin
      if (z[i]) acc = acc ^ ({{(HW-1){1'b0}}, x} << i);
    end
    return acc;
  endfunction

  logic [HW-1:0]     a_lo, a_hi, b_lo, b_hi;
  logic [2*HW-2:0]   p_lo, p_hi, p_mid;

  // Three half-size products; the middle term recovers the cross products.
  always_comb begin
    a_lo  = a[HW-1:0];
    b_lo  = b[HW-1:0];
    a_hi  = {1'b0, a[192:HW]};
    b_hi  = {1'b0, b[192:HW]};
    p_lo  = clmul_half(a_lo, b_lo);
    p_hi  = clmul_half(a_hi, b_hi);
    p_mid = clmul_half(a_lo ^ a_hi, b_lo ^ b_hi) ^ p_lo ^ p_hi;
    y     = {192'b0, p_lo}
          ^ ({192'b0, p_mid} << HW)
          ^ ({192'b0, p_hi} << (2 * HW));
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Purely combinational; the caller owns the
// pointer register and passes in the id that won last time.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // On contention the requester that did not win last time goes next.
  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    if (valid == 2'b11) begin
      gnt_id = ~last;
    end else begin
      gnt_id = valid[1];
    end
    if (valid != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ka193_mul_sched.sv
// Two-requester scheduler around one shared KA_193bit multiplier. Operands
// are registered and held for MUL_LAT cycles before the product is captured.
// Optional performance counters are built when KA_SCHED_PERF_EN is defined.
module ka193_mul_sched
  import ka193_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [FIELD_W-1:0] req0_a,
  input  logic [FIELD_W-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [FIELD_W-1:0] req1_a,
  input  logic [FIELD_W-1:0] req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [PROD_W-1:0]  rsp_y,
  output logic               rsp_id,
  output logic               busy
`ifdef KA_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]   op_cnt0,
  output logic [CNT_W-1:0]   op_cnt1,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  if (MUL_LAT < 1 || MUL_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("ka193_mul_sched: MUL_LAT must be 1..15 and CNT_W >= 1");
  end

  state_t             state, state_nxt;
  logic [FIELD_W-1:0] op_a, op_b;
  logic [PROD_W-1:0]  mul_y;
  logic [3:0]         lat_cnt;
  req_id_t            last;
  req_id_t            gnt_id;
  logic [1:0]         gnt;
  logic               accept;
  logic               rsp_fire;

  rr_arb2 u_arb (
    .valid  ({req1_valid, req0_valid}),
    .last   (last),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  KA_193bit u_mul (
    .a (op_a),
    .b (op_b),
    .y (mul_y)
  );

  assign accept   = (state == IDLE) && (gnt != 2'b00);
  assign rsp_fire = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (lat_cnt == 4'd0) state_nxt = DONE;
      DONE:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; ready is only offered while idle.
  always_comb begin
    req0_ready = (state == IDLE) && gnt[0];
    req1_ready = (state == IDLE) && gnt[1];
    busy       = (state != IDLE);
  end

  // Operand latch, settle countdown, product capture and response hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      lat_cnt   <= 4'd0;
      last      <= 1'b1;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= gnt_id ? req1_a : req0_a;
            op_b    <= gnt_id ? req1_b : req0_b;
            rsp_id  <= gnt_id;
            last    <= gnt_id;
            lat_cnt <= 4'(MUL_LAT - 1);
          end
        end
        CALC: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            rsp_y     <= mul_y;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_fire) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef KA_SCHED_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating completion and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt0   <= '0;
      op_cnt1   <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == DONE && rsp_fire) begin
        if (!rsp_id && op_cnt0 != CNT_MAX) op_cnt0 <= op_cnt0 + 1'b1;
        if ( rsp_id && op_cnt1 != CNT_MAX) op_cnt1 <= op_cnt1 + 1'b1;
      end
      if (state == DONE && !rsp_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ka193_mul_sched.sv
// Directed bench for ka193_mul_sched with MUL_LAT=4.
module tb_ka193_mul_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [192:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [384:0] rsp_y;
`ifdef KA_SCHED_PERF_EN
  logic [15:0]  op_cnt0, op_cnt1, stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ka193_mul_sched #(.MUL_LAT(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef KA_SCHED_PERF_EN
    ,
    .op_cnt0    (op_cnt0),
    .op_cnt1    (op_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [384:0] obs, input logic [384:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One single-requester operation with rsp_ready high; called #1 after a posedge.
  task automatic do_op(input bit id, input logic [192:0] a, input logic [192:0] b,
                       input logic [384:0] exp, input string tag);
    int n;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_y"}, rsp_y, exp);
    chk({tag, "_id"}, rsp_id, id);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [192:0] top, top1, ones8;
    logic [384:0] e_top, e_top1;
    int           n, prev_cyc;
    bit           seen;

    top   = '0; top[192] = 1'b1;
    top1  = top; top1[0] = 1'b1;
    e_top = '0; e_top[384] = 1'b1;
    e_top1 = e_top; e_top1[0] = 1'b1;
    ones8 = 193'hFF;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;

    @(negedge clk);
    chk("reset_ctrl", {busy, rsp_valid, rsp_id, req0_ready, req1_ready}, 5'b0);
    chk("reset_y", rsp_y, 385'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 193'd1, 193'd1, 385'd1, "basic");
    do_op(1'b0, 193'd3, 193'd3, 385'd5, "clmul3x3");
    do_op(1'b1, top, top, e_top, "topbit");
    do_op(1'b0, top1, top1, e_top1, "top_plus_one");
    do_op(1'b1, ones8, ones8, 385'h5555, "ff_sq");
    do_op(1'b0, ones8, 193'd3, 385'h101, "ff_x3");

    // Backpressure: response held for 5 cycles while req0 waits.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 193'd3; req1_b = 193'd6;
    #1;
    chk("bp_ready", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_lat", n, 4);
    req0_valid = 1'b1; req0_a = 193'd5; req0_b = 193'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ctrl", {rsp_valid, rsp_id, req0_ready, req1_ready}, 4'b1100);
      chk("bp_hold_y", rsp_y, 385'd10);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {rsp_valid, req0_ready}, 2'b01);
`ifdef KA_SCHED_PERF_EN
    chk("perf_op0", op_cnt0, 16'd4);
    chk("perf_op1", op_cnt1, 16'd3);
    chk("perf_stall", stall_cnt, 16'd5);
`endif

    // Reset while lat_cnt is 2: everything clears at once, nothing emitted.
    @(posedge clk); #1;
    chk("rst_pre_busy", busy, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {busy, rsp_valid, rsp_id, req0_ready, req1_ready}, 5'b0);
    chk("rst_async_y", rsp_y, 385'd0);
`ifdef KA_SCHED_PERF_EN
    chk("rst_perf", {op_cnt0, op_cnt1, stall_cnt}, 48'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    chk("rst_no_rsp", seen, 1'b0);

    // Arbitration: both requesters held valid for four operations.
    req0_valid = 1'b1; req0_a = 193'd3; req0_b = 193'd3;
    req1_valid = 1'b1; req1_a = ones8; req1_b = ones8;
    prev_cyc = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin @(posedge clk); #1; n++; end
      chk("arb_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) chk("arb_spacing", cyc - prev_cyc, 6);
      prev_cyc = cyc;
      @(posedge clk); #1;
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      chk("arb_busy", busy, 1'b1);
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("arb_id", rsp_id, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk("arb_y", rsp_y, (k % 2 == 1) ? 385'h5555 : 385'd5);
    end
    @(posedge clk); #1;
    chk("arb_end_idle", {rsp_valid, busy}, 2'b00);
`ifdef KA_SCHED_PERF_EN
    chk("arb_perf", {op_cnt0, op_cnt1, stall_cnt}, {16'd2, 16'd2, 16'd0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
